// File: rtl/pcm_mm_responder.sv
// rtl/pcm_mm_responder.sv - PCM memory-mapped responder with fixed read/write latency
//
// Purpose: memory endpoint for the PCM arbiter port. Accepts single-word read
// and write requests, stores data in an internal 16-bit word array and models
// phase-change-memory timing with a short read latency and a long write busy
// time, back-pressured through waitrequest.
//
// Optional feature macro: PCM_MM_DIFF_WRITE_EN
//   defined   - differential write: a write whose enabled bytes already match
//               the array is skipped (one busy cycle, no commit, no count).
//   undefined - every write takes WRITE_LAT cycles and is counted.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   pcm_mem_mm_address         word address (only [DEPTH_W-1:0] decoded)
//   pcm_mem_mm_chipselect      request qualifier
//   pcm_mem_mm_clken           request qualifier
//   pcm_mem_mm_write           1 = write, 0 = read
//   pcm_mem_mm_writedata       write data
//   pcm_mem_mm_byteenable      per-byte write enables
//   pcm_mem_mm_readdata        read data, holds last value between pulses
//   pcm_mem_mm_readdatavalid   one-cycle read data pulse
//   pcm_mem_mm_waitrequest     high while busy
//   wr_commit_cnt              saturating count of committed writes

module pcm_mm_responder #(
  parameter int DEPTH_W   = 10,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] pcm_mem_mm_address,
  input  logic        pcm_mem_mm_chipselect,
  input  logic        pcm_mem_mm_clken,
  input  logic        pcm_mem_mm_write,
  input  logic [15:0] pcm_mem_mm_writedata,
  input  logic [1:0]  pcm_mem_mm_byteenable,
  output logic [15:0] pcm_mem_mm_readdata,
  output logic        pcm_mem_mm_readdatavalid,
  output logic        pcm_mem_mm_waitrequest,
  output logic [15:0] wr_commit_cnt
);

  localparam int DEPTH = 1 << DEPTH_W;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_READ_WAIT  = 2'd1;
  localparam logic [1:0] ST_WRITE_BUSY = 2'd2;

  localparam logic [7:0] RD_LOAD = 8'(READ_LAT - 1);
  localparam logic [7:0] WR_LOAD = 8'(WRITE_LAT - 1);

  // Array is deliberately outside the reset domain: contents survive reset.
  logic [15:0]        mem_q [DEPTH];

  logic [1:0]         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [DEPTH_W-1:0] addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic [1:0]         be_q, be_d;
  logic               skip_q, skip_d;
  logic [15:0]        rdata_q, rdata_d;
  logic [15:0]        commit_q, commit_d;

  logic               req;
  logic               last;
  logic [15:0]        cur_word;
  logic [15:0]        merged_word;
  logic               do_commit;
  logic               in_same;
  logic               unused_addr;

  assign req         = pcm_mem_mm_chipselect & pcm_mem_mm_clken;
  assign last        = (cnt_q == 8'd0);
  assign cur_word    = mem_q[addr_q];
  assign merged_word = {be_q[1] ? wdata_q[15:8] : cur_word[15:8],
                        be_q[0] ? wdata_q[7:0]  : cur_word[7:0]};
  assign do_commit   = (state_q == ST_WRITE_BUSY) && last && !skip_q;
  assign unused_addr = ^pcm_mem_mm_address[19:DEPTH_W];

`ifdef PCM_MM_DIFF_WRITE_EN
  // Compare the incoming write against the currently stored word; a write
  // that would not change any enabled byte is treated as already done.
  logic [15:0] in_word;
  logic [15:0] in_merged;
  assign in_word   = mem_q[pcm_mem_mm_address[DEPTH_W-1:0]];
  assign in_merged = {pcm_mem_mm_byteenable[1] ? pcm_mem_mm_writedata[15:8] : in_word[15:8],
                      pcm_mem_mm_byteenable[0] ? pcm_mem_mm_writedata[7:0]  : in_word[7:0]};
  assign in_same   = (in_merged == in_word);
`else
  assign in_same   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    skip_d   = skip_q;
    rdata_d  = rdata_q;
    commit_d = commit_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = pcm_mem_mm_address[DEPTH_W-1:0];
          wdata_d = pcm_mem_mm_writedata;
          be_d    = pcm_mem_mm_byteenable;
          if (pcm_mem_mm_write) begin
            state_d = ST_WRITE_BUSY;
            // A skipped write still spends its one busy cycle in WRITE_BUSY.
            skip_d  = in_same;
            cnt_d   = in_same ? 8'd0 : WR_LOAD;
          end else begin
            state_d = ST_READ_WAIT;
            skip_d  = 1'b0;
            cnt_d   = RD_LOAD;
          end
        end
      end
      ST_READ_WAIT: begin
        if (last) begin
          rdata_d = cur_word;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_WRITE_BUSY: begin
        if (last) begin
          state_d = ST_IDLE;
          if (!skip_q && (commit_q != 16'hFFFF)) begin
            commit_d = commit_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= '0;
      wdata_q  <= 16'h0000;
      be_q     <= 2'b00;
      skip_q   <= 1'b0;
      rdata_q  <= 16'h0000;
      commit_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      skip_q   <= skip_d;
      rdata_q  <= rdata_d;
      commit_q <= commit_d;
    end
  end

  // Reset at the commit edge aborts the write.
  always_ff @(posedge clk) begin
    if (!reset && do_commit) begin
      mem_q[addr_q] <= merged_word;
    end
  end

  assign pcm_mem_mm_waitrequest   = (state_q != ST_IDLE);
  assign pcm_mem_mm_readdatavalid = (state_q == ST_READ_WAIT) && last;
  // During the pulse the array word is driven directly; afterwards the
  // registered copy keeps the last returned value on the bus.
  assign pcm_mem_mm_readdata      = pcm_mem_mm_readdatavalid ? cur_word : rdata_q;
  assign wr_commit_cnt            = commit_q;

endmodule

// File: tb/tb_pcm_mm_responder.sv
// tb/tb_pcm_mm_responder.sv - self-checking bench for pcm_mm_responder

module tb_pcm_mm_responder;

  localparam int DEPTH_W   = 10;
  localparam int READ_LAT  = 2;
  localparam int WRITE_LAT = 8;
  localparam int DEPTH     = 1 << DEPTH_W;

  logic        clk;
  logic        reset;
  logic [19:0] address;
  logic        chipselect;
  logic        clken;
  logic        write;
  logic [15:0] writedata;
  logic [1:0]  byteenable;
  logic [15:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic [15:0] wr_commit_cnt;

  int vec  = 0;
  int errs = 0;

  logic [15:0] mm [DEPTH];
  int          model_cnt;

  pcm_mm_responder #(
    .DEPTH_W  (DEPTH_W),
    .READ_LAT (READ_LAT),
    .WRITE_LAT(WRITE_LAT)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .pcm_mem_mm_address      (address),
    .pcm_mem_mm_chipselect   (chipselect),
    .pcm_mem_mm_clken        (clken),
    .pcm_mem_mm_write        (write),
    .pcm_mem_mm_writedata    (writedata),
    .pcm_mem_mm_byteenable   (byteenable),
    .pcm_mem_mm_readdata     (readdata),
    .pcm_mem_mm_readdatavalid(readdatavalid),
    .pcm_mem_mm_waitrequest  (waitrequest),
    .wr_commit_cnt           (wr_commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] be);
    logic [15:0] lo, hi;
    lo = be[0] ? (d & 16'h00FF) : (old & 16'h00FF);
    hi = be[1] ? (d & 16'hFF00) : (old & 16'hFF00);
    return hi | lo;
  endfunction

  function automatic int idx(input logic [19:0] a);
    return int'(a) % DEPTH;
  endfunction

  task automatic drop_req();
    chipselect = 1'b0;
    clken      = 1'b0;
    write      = 1'b0;
  endtask

  // Called at a negedge in an idle cycle; returns at the negedge of the
  // first idle cycle after the transaction.
  task automatic txn(input bit wr, input logic [19:0] a, input logic [15:0] d,
                     input logic [1:0] be, input string tag);
    int          exp_busy;
    logic [15:0] old, nw;
    bit          skip;
    int          idle_k, rv_n, rv_k;
    logic [15:0] rv_d;
    old  = mm[idx(a)];
    nw   = merge(old, d, be);
    skip = 1'b0;
`ifdef PCM_MM_DIFF_WRITE_EN
    if (wr) skip = (nw == old);
`endif
    exp_busy = wr ? (skip ? 1 : WRITE_LAT) : READ_LAT;
    chipselect = 1'b1;
    clken      = 1'b1;
    write      = wr;
    address    = a;
    writedata  = d;
    byteenable = be;
    @(posedge clk);
    #1;
    drop_req();
    idle_k = -1;
    rv_n   = 0;
    rv_k   = -1;
    rv_d   = 16'h0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (readdatavalid) begin
        rv_n++;
        rv_k = k;
        rv_d = readdata;
      end
      if (!waitrequest) begin
        idle_k = k;
        break;
      end
    end
    check({tag, ".idle_cycle"}, idle_k, exp_busy + 1);
    if (wr) begin
      if (!skip) begin
        mm[idx(a)] = nw;
        if (model_cnt < 65535) model_cnt++;
      end
      check({tag, ".no_rdv"}, rv_n, 0);
      check({tag, ".commit_cnt"}, wr_commit_cnt, model_cnt);
    end else begin
      check({tag, ".rdv_count"}, rv_n, 1);
      check({tag, ".rdv_cycle"}, rv_k, READ_LAT);
      check({tag, ".rdata"}, rv_d, old);
      check({tag, ".rdata_hold"}, readdata, old);
    end
  endtask

  initial begin
    logic [63:0] wait_obs, wait_exp, rv_obs, rv_exp;
    logic [19:0] a;
    logic [15:0] d;
    bit          wr;
    int          nc;

    for (int i = 0; i < DEPTH; i++) mm[i] = 16'h0000;
    model_cnt = 0;
    reset = 1'b1;
    drop_req();
    address    = '0;
    writedata  = '0;
    byteenable = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset.waitrequest", waitrequest, 1'b0);
    check("reset.readdatavalid", readdatavalid, 1'b0);
    check("reset.readdata", readdata, 16'h0000);
    check("reset.commit_cnt", wr_commit_cnt, 16'h0000);

    txn(1'b0, 20'h00005, 16'h0000, 2'b00, "rd_0005");
    txn(1'b1, 20'h00010, 16'hBEEF, 2'b11, "wr_beef");
    check("wr_beef.count_is_1", wr_commit_cnt, 16'd1);
    txn(1'b0, 20'h00010, 16'h0000, 2'b00, "rd_beef");
    check("rd_beef.value", readdata, 16'hBEEF);
    txn(1'b1, 20'h00010, 16'h1234, 2'b01, "wr_1234_be01");
    txn(1'b0, 20'h00010, 16'h0000, 2'b10, "rd_be34");
    check("rd_be34.value", readdata, 16'hBE34);
    txn(1'b0, 20'h00410, 16'h0000, 2'b00, "rd_alias");
    check("rd_alias.value", readdata, 16'hBE34);
    txn(1'b1, 20'h00010, 16'hBE34, 2'b11, "wr_same");
    txn(1'b1, 20'h00011, 16'h5555, 2'b00, "wr_be00");
    txn(1'b0, 20'h00011, 16'h0000, 2'b00, "rd_be00");

    // Reset during cycle 4 of a write.
    chipselect = 1'b1;
    clken      = 1'b1;
    write      = 1'b1;
    address    = 20'h00020;
    writedata  = 16'hAAAA;
    byteenable = 2'b11;
    @(posedge clk);
    #1 drop_req();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_cnt = 0;
    @(negedge clk);
    check("midrst.waitrequest", waitrequest, 1'b0);
    check("midrst.readdatavalid", readdatavalid, 1'b0);
    check("midrst.readdata", readdata, 16'h0000);
    check("midrst.commit_cnt", wr_commit_cnt, 16'h0000);
    txn(1'b0, 20'h00020, 16'h0000, 2'b00, "midrst.rd_0020");

    // Reset in the same cycle as a request.
    reset      = 1'b1;
    chipselect = 1'b1;
    clken      = 1'b1;
    write      = 1'b0;
    address    = 20'h00010;
    @(posedge clk);
    #1 reset = 1'b0;
    drop_req();
    @(negedge clk);
    check("rstreq.waitrequest", waitrequest, 1'b0);
    check("rstreq.readdata", readdata, 16'h0000);
    @(negedge clk);
    check("rstreq.no_rdv", readdatavalid, 1'b0);

    // chipselect without clken is not a request.
    chipselect = 1'b1;
    clken      = 1'b0;
    write      = 1'b1;
    address    = 20'h00030;
    writedata  = 16'h7777;
    byteenable = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("noclken.waitrequest", waitrequest, 1'b0);
    end
    drop_req();
    txn(1'b0, 20'h00030, 16'h0000, 2'b00, "noclken.rd_0030");
    check("noclken.commit_cnt", wr_commit_cnt, model_cnt);

    // Read held through busy: second acceptance at the first idle cycle.
    chipselect = 1'b1;
    clken      = 1'b1;
    write      = 1'b0;
    address    = 20'h00010;
    wait_obs = '0;
    wait_exp = '0;
    rv_obs   = '0;
    rv_exp   = '0;
    for (int k = 1; k <= 2 * (READ_LAT + 1); k++) begin
      @(negedge clk);
      wait_obs[k] = waitrequest;
      rv_obs[k]   = readdatavalid;
      wait_exp[k] = (k % (READ_LAT + 1)) != 0;
      rv_exp[k]   = (k % (READ_LAT + 1)) == READ_LAT;
      if (readdatavalid) check("held.rdata", readdata, mm[idx(20'h00010)]);
    end
    drop_req();
    check("held.waitrequest_pattern", wait_obs, wait_exp);
    check("held.rdv_pattern", rv_obs, rv_exp);

    // Randomized traffic over a small low-address window with aliasing.
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1));
      nc = int'($urandom_range(0, 15));
      a  = {10'($urandom), 10'(nc)};
      d  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) d = mm[idx(a)];
      txn(wr, a, d, 2'($urandom), wr ? "rand_wr" : "rand_rd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
